// File: rtl/alu_rr_arbiter.sv
// ============================================================================
// alu_rr_arbiter: round-robin sharing of one registered ALU between two
// requesters, sequenced IDLE -> ISSUE -> RESULT with a one-cycle response.
// Revision: 1.0
// ============================================================================
`default_nettype none

module alu_rr_arbiter #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic [1:0]       req0_op,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  input  logic [1:0]       req1_op,
  output logic             rsp0_valid,
  output logic             rsp1_valid,
  output logic [WIDTH-1:0] rsp_data,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [1:0]       alu_op,
  input  logic [WIDTH-1:0] alu_c,
  output logic             busy,
  output logic [CNT_W-1:0] done_cnt
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ISSUE  = 2'd1,
    RESULT = 2'd2
  } state_t;

  state_t state;
  logic   owner;
  logic   last_grant;
  logic   pick0;
  logic   pick1;

  // Under contention the requester that did not win last time takes the grant.
  always_comb begin
    pick1      = req1_valid && (!req0_valid || !last_grant);
    pick0      = req0_valid && !pick1;
    req0_ready = (state == IDLE) && pick0;
    req1_ready = (state == IDLE) && pick1;
    busy       = (state != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      alu_a      <= '0;
      alu_b      <= '0;
      alu_op     <= '0;
      rsp_data   <= '0;
      rsp0_valid <= 1'b0;
      rsp1_valid <= 1'b0;
      done_cnt   <= '0;
      owner      <= 1'b0;
      last_grant <= 1'b1;
    end else begin
      rsp0_valid <= 1'b0;
      rsp1_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (req0_ready) begin
            alu_a      <= req0_a;
            alu_b      <= req0_b;
            alu_op     <= req0_op;
            owner      <= 1'b0;
            last_grant <= 1'b0;
            state      <= ISSUE;
          end else if (req1_ready) begin
            alu_a      <= req1_a;
            alu_b      <= req1_b;
            alu_op     <= req1_op;
            owner      <= 1'b1;
            last_grant <= 1'b1;
            state      <= ISSUE;
          end
        end
        ISSUE: begin
          state <= RESULT;
        end
        RESULT: begin
          rsp_data <= alu_c;
          if (owner) begin
            rsp1_valid <= 1'b1;
          end else begin
            rsp0_valid <= 1'b1;
          end
          done_cnt <= done_cnt + CNT_W'(1);
          state    <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_alu_rr_arbiter.sv
// ============================================================================
// tb_alu_rr_arbiter: directed stimulus against a cycle-indexed model of the
// arbiter plus a registered ALU stand-in.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_alu_rr_arbiter;

  localparam int WIDTH = 8;
  localparam int CW    = 4;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             req0_valid = 1'b0, req1_valid = 1'b0;
  logic             req0_ready, req1_ready;
  logic [WIDTH-1:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
  logic [1:0]       req0_op = '0, req1_op = '0;
  logic             rsp0_valid, rsp1_valid;
  logic [WIDTH-1:0] rsp_data;
  logic [WIDTH-1:0] alu_a, alu_b;
  logic [1:0]       alu_op;
  logic [WIDTH-1:0] alu_c = '0;
  logic             busy;
  logic [CW-1:0]    done_cnt;

  int n_cmp = 0;
  int n_err = 0;
  bit run   = 1'b0;

  alu_rr_arbiter #(.WIDTH(WIDTH), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready),
    .req0_a(req0_a), .req0_b(req0_b), .req0_op(req0_op),
    .req1_valid(req1_valid), .req1_ready(req1_ready),
    .req1_a(req1_a), .req1_b(req1_b), .req1_op(req1_op),
    .rsp0_valid(rsp0_valid), .rsp1_valid(rsp1_valid), .rsp_data(rsp_data),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_c(alu_c),
    .busy(busy), .done_cnt(done_cnt)
  );

  always #5 clk = ~clk;

  function automatic logic [WIDTH-1:0] alu_fn(input logic [WIDTH-1:0] a, b, input logic [1:0] op);
    case (op)
      2'd0:    return a + b;
      2'd1:    return a - b;
      2'd2:    return a & b;
      default: return a | b;
    endcase
  endfunction

  // Registered ALU stand-in: one cycle from operands to c.
  always @(posedge clk) alu_c <= alu_fn(alu_a, alu_b, alu_op);

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: cycle index t counts negedges; each accept occupies the arbiter
  // for three cycles and schedules its response for the third one.
  typedef struct {
    int               due;
    bit               owner;
    logic [WIDTH-1:0] data;
  } exp_t;

  exp_t             q[$];
  int               t = 0;
  int               free_at = 0;
  bit               m_last = 1'b1;
  logic [WIDTH-1:0] m_a = '0, m_b = '0;
  logic [1:0]       m_op = '0;
  int               m_cnt = 0;

  always @(negedge clk) begin
    if (run) begin
      bit idle, g0, g1, e0, e1;
      logic [WIDTH-1:0] ed;
      exp_t p;
      t++;
      if (!rst_n) begin
        free_at = t;
        q.delete();
        m_last = 1'b1;
        m_a = '0; m_b = '0; m_op = '0; m_cnt = 0;
      end
      idle = (t >= free_at);
      e0 = 1'b0; e1 = 1'b0; ed = '0;
      if (q.size() > 0 && q[0].due == t) begin
        p = q.pop_front();
        e0 = !p.owner;
        e1 = p.owner;
        ed = p.data;
        m_cnt = (m_cnt + 1) % (1 << CW);
      end
      g0 = 1'b0; g1 = 1'b0;
      if (idle) begin
        if (req0_valid && req1_valid) begin
          if (m_last) g0 = 1'b1; else g1 = 1'b1;
        end else if (req0_valid) g0 = 1'b1;
        else if (req1_valid) g1 = 1'b1;
      end
      chk("ready0", req0_ready, g0);
      chk("ready1", req1_ready, g1);
      chk("busy", busy, !idle);
      chk("rsp0_valid", rsp0_valid, e0);
      chk("rsp1_valid", rsp1_valid, e1);
      if (e0 || e1) chk("rsp_data", rsp_data, ed);
      chk("alu_a", alu_a, m_a);
      chk("alu_b", alu_b, m_b);
      chk("alu_op", alu_op, m_op);
      chk("done_cnt", done_cnt, m_cnt);
      if (rst_n && (g0 || g1)) begin
        p.owner = g1;
        m_a  = g1 ? req1_a : req0_a;
        m_b  = g1 ? req1_b : req0_b;
        m_op = g1 ? req1_op : req0_op;
        p.data = alu_fn(m_a, m_b, m_op);
        p.due  = t + 3;
        q.push_back(p);
        m_last  = g1;
        free_at = t + 3;
      end
    end
  end

  task automatic reset_dut();
    @(posedge clk); #1;
    rst_n = 1'b0; req0_valid = 1'b0; req1_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic do_op(input bit who, input logic [WIDTH-1:0] a, b, input logic [1:0] op,
                       input logic [WIDTH-1:0] exp, input string nm);
    bit got;
    @(posedge clk); #1;
    if (who) begin req1_a = a; req1_b = b; req1_op = op; req1_valid = 1'b1; end
    else     begin req0_a = a; req0_b = b; req0_op = op; req0_valid = 1'b1; end
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      if (who ? req1_ready : req0_ready) got = 1'b1;
    end
    if (!got) chk({nm, "_grant_timeout"}, 0, 1);
    @(posedge clk); #1;
    req0_valid = 1'b0; req1_valid = 1'b0;
    got = 1'b0;
    for (int i = 0; i < 6 && !got; i++) begin
      @(negedge clk);
      if (who ? rsp1_valid : rsp0_valid) begin
        got = 1'b1;
        chk(nm, rsp_data, exp);
      end
    end
    if (!got) chk({nm, "_rsp_timeout"}, 0, 1);
  endtask

  initial begin
    int g_own[$];
    int g_time[$];
    bit got;
    run = 1'b1;
    reset_dut();

    // 1: single op from requester 0
    do_op(1'b0, 8'd7, 8'd3, 2'd0, 8'd10, "t1_add");
    chk("t1_cnt", done_cnt, 1);

    // 2: requester 1, all opcodes and a wrapping subtract
    do_op(1'b1, 8'd7, 8'd3, 2'd1, 8'd4,   "t2_sub");
    do_op(1'b1, 8'd7, 8'd3, 2'd2, 8'd3,   "t2_and");
    do_op(1'b1, 8'd7, 8'd3, 2'd3, 8'd7,   "t2_or");
    do_op(1'b1, 8'd3, 8'd7, 2'd1, 8'hFC,  "t2_wrap");

    // 3: continuous contention from reset
    reset_dut();
    req0_a = 8'd1; req0_b = 8'd1; req0_op = 2'd0;
    req1_a = 8'd5; req1_b = 8'd2; req1_op = 2'd1;
    req0_valid = 1'b1; req1_valid = 1'b1;
    for (int i = 0; i < 13; i++) begin
      @(negedge clk);
      if (req0_ready) begin g_own.push_back(0); g_time.push_back(i); end
      if (req1_ready) begin g_own.push_back(1); g_time.push_back(i); end
    end
    @(posedge clk); #1;
    req0_valid = 1'b0; req1_valid = 1'b0;
    chk("t3_ngrants", (g_own.size() >= 4), 1);
    if (g_own.size() >= 4) begin
      chk("t3_g0", g_own[0], 0);
      chk("t3_g1", g_own[1], 1);
      chk("t3_g2", g_own[2], 0);
      chk("t3_g3", g_own[3], 1);
      chk("t3_gap1", g_time[1] - g_time[0], 3);
      chk("t3_gap3", g_time[3] - g_time[2], 3);
    end
    repeat (6) @(posedge clk);

    // 4: requester 0 valid only while busy
    reset_dut();
    @(posedge clk); #1;
    req1_a = 8'd2; req1_b = 8'd2; req1_op = 2'd0; req1_valid = 1'b1;
    got = 1'b0;
    for (int i = 0; i < 10 && !got; i++) begin
      @(negedge clk);
      if (req1_ready) got = 1'b1;
    end
    if (!got) chk("t4_grant_timeout", 0, 1);
    @(posedge clk); #1;
    req1_valid = 1'b0; req0_valid = 1'b1;
    @(posedge clk);
    @(posedge clk); #1;
    req0_valid = 1'b0;
    repeat (6) @(posedge clk);
    #1 chk("t4_cnt", done_cnt, 1);

    // 5: reset one cycle after a handshake
    reset_dut();
    @(posedge clk); #1;
    req0_a = 8'd9; req0_b = 8'd9; req0_op = 2'd0; req0_valid = 1'b1;
    got = 1'b0;
    for (int i = 0; i < 10 && !got; i++) begin
      @(negedge clk);
      if (req0_ready) got = 1'b1;
    end
    if (!got) chk("t5_grant_timeout", 0, 1);
    @(posedge clk); #1;
    req0_valid = 1'b0; rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    req0_valid = 1'b1; req1_valid = 1'b1;
    @(negedge clk);
    chk("t5_alu_a", alu_a, 0);
    chk("t5_cnt", done_cnt, 0);
    chk("t5_first_r0", req0_ready, 1);
    chk("t5_first_r1", req1_ready, 0);
    @(posedge clk); #1;
    req0_valid = 1'b0; req1_valid = 1'b0;
    repeat (5) @(negedge clk);

    // 6: counter wrap over 16 operations
    reset_dut();
    for (int i = 0; i < 16; i++) begin
      do_op(i[0], 8'(i), 8'd2, 2'd0, 8'(i + 2), "t6_op");
      if (i == 14) chk("t6_cnt15", done_cnt, 15);
      if (i == 15) chk("t6_wrap", done_cnt, 0);
    end

    repeat (4) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
